// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the core MEM stage and an
// external debug/DMA port; core has priority, ext gets bounded starvation.
module dmem_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 9,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_rd,
  input  logic              core_wr,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wr_data,
  output logic              core_stall,
  output logic              core_rd_valid,
  output logic [DATA_W-1:0] core_rd_data,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wr_data,
  output logic              ext_gnt,
  output logic              ext_rd_valid,
  output logic [DATA_W-1:0] ext_rd_data,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CORE,
    OWN_EXT
  } owner_e;

  localparam logic [3:0] MaxW = 4'(MAX_WAIT);

  owner_e     owner_q, owner_d;
  logic [3:0] wait_q, wait_d;

  logic core_req;
  logic ext_win;
  logic core_win;

  assign core_req = core_rd | core_wr;
  assign ext_win  = ext_req & (~core_req | (wait_q == MaxW));
  assign core_win = core_req & ~ext_win;

  assign ext_gnt    = ext_win;
  assign core_stall = core_req & ext_win;

  always_comb begin
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    unique case (1'b1)
      ext_win: begin
        mem_rd      = ~ext_we;
        mem_wr      = ext_we;
        mem_addr    = ext_addr;
        mem_wr_data = ext_wr_data;
      end
      core_win: begin
        // a store wins over a simultaneous load strobe
        mem_rd      = core_rd & ~core_wr;
        mem_wr      = core_wr;
        mem_addr    = core_addr;
        mem_wr_data = core_wr_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (!ext_req || ext_win)
      wait_d = '0;
    else if (wait_q != MaxW)
      wait_d = wait_q + 4'd1;
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (core_win && core_rd && !core_wr)
      owner_d = OWN_CORE;
    else if (ext_win && !ext_we)
      owner_d = OWN_EXT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_q  <= '0;
      owner_q <= OWN_NONE;
    end else begin
      wait_q  <= wait_d;
      owner_q <= owner_d;
    end
  end

  assign core_rd_valid = (owner_q == OWN_CORE);
  assign ext_rd_valid  = (owner_q == OWN_EXT);
  assign core_rd_data  = core_rd_valid ? mem_rd_data : '0;
  assign ext_rd_data   = ext_rd_valid ? mem_rd_data : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a synchronous-read memory model
// and immediate-assertion checks.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        core_rd, core_wr;
  logic [8:0]  core_addr;
  logic [31:0] core_wr_data;
  logic        core_stall, core_rd_valid;
  logic [31:0] core_rd_data;
  logic        ext_req, ext_we;
  logic [8:0]  ext_addr;
  logic [31:0] ext_wr_data;
  logic        ext_gnt, ext_rd_valid;
  logic [31:0] ext_rd_data;
  logic        mem_rd, mem_wr;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;

  logic [31:0] mem [512];

  int n_cmp = 0;
  int n_err = 0;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(9), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .core_rd(core_rd), .core_wr(core_wr),
    .core_addr(core_addr), .core_wr_data(core_wr_data),
    .core_stall(core_stall), .core_rd_valid(core_rd_valid),
    .core_rd_data(core_rd_data),
    .ext_req(ext_req), .ext_we(ext_we),
    .ext_addr(ext_addr), .ext_wr_data(ext_wr_data),
    .ext_gnt(ext_gnt), .ext_rd_valid(ext_rd_valid),
    .ext_rd_data(ext_rd_data),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial mem_rd_data = '0;

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wr_data;
    if (mem_rd) mem_rd_data <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_rd = 0; core_wr = 0; core_addr = '0; core_wr_data = '0;
    ext_req = 0; ext_we = 0; ext_addr = '0; ext_wr_data = '0;
  endtask

  function automatic logic [31:0] all_out();
    return {26'(0), core_stall, core_rd_valid, ext_gnt,
            ext_rd_valid, mem_rd, mem_wr} |
           core_rd_data | ext_rd_data | 32'(mem_addr) | mem_wr_data;
  endfunction

  initial begin
    reset = 1'b0;
    idle_inputs();
    #3;
    chk("reset_outs", all_out(), 32'h0);
    chk("reset_crv", 32'(core_rd_valid), 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;

    // preload through both ports
    tick(); core_wr = 1; core_addr = 9'h001; core_wr_data = 32'hA;
    tick(); core_addr = 9'h002; core_wr_data = 32'hB;
    tick(); core_wr = 0;
    ext_req = 1; ext_we = 1; ext_addr = 9'h1FF; ext_wr_data = 32'h12345678;
    @(negedge clk);
    chk("ext_wr_gnt", 32'(ext_gnt), 32'h1);
    chk("ext_wr_memwr", 32'(mem_wr), 32'h1);
    tick(); idle_inputs();

    // core-only write then read
    tick(); core_wr = 1; core_addr = 9'h005; core_wr_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("core_wr_memwr", 32'(mem_wr), 32'h1);
    chk("core_wr_stall", 32'(core_stall), 32'h0);
    tick(); core_wr = 0; core_rd = 1;
    @(negedge clk);
    chk("core_rd_stall", 32'(core_stall), 32'h0);
    chk("core_rd_memrd", 32'(mem_rd), 32'h1);
    tick(); core_rd = 0;
    @(negedge clk);
    chk("core_rd_valid", 32'(core_rd_valid), 32'h1);
    chk("core_rd_data", core_rd_data, 32'hDEADBEEF);

    // ext-only read
    tick(); ext_req = 1; ext_we = 0; ext_addr = 9'h1FF;
    @(negedge clk);
    chk("ext_rd_gnt", 32'(ext_gnt), 32'h1);
    chk("ext_rd_memrd", 32'(mem_rd), 32'h1);
    tick(); ext_req = 0;
    @(negedge clk);
    chk("ext_rd_valid", 32'(ext_rd_valid), 32'h1);
    chk("ext_rd_data", ext_rd_data, 32'h12345678);
    chk("ext_rd_nocore", 32'(core_rd_valid), 32'h0);

    // interleaved reads by different owners
    tick(); core_rd = 1; core_addr = 9'h001;
    tick(); core_rd = 0; ext_req = 1; ext_we = 0; ext_addr = 9'h002;
    @(negedge clk);
    chk("il_core_valid", 32'(core_rd_valid), 32'h1);
    chk("il_core_data", core_rd_data, 32'hA);
    chk("il_ext_quiet", 32'(ext_rd_valid), 32'h0);
    chk("il_ext_gnt", 32'(ext_gnt), 32'h1);
    tick(); ext_req = 0;
    @(negedge clk);
    chk("il_ext_valid", 32'(ext_rd_valid), 32'h1);
    chk("il_ext_data", ext_rd_data, 32'hB);
    chk("il_core_quiet", 32'(core_rd_valid), 32'h0);
    chk("il_core_data0", core_rd_data, 32'h0);

    // starvation: ext preempts every MAX_WAIT+1 cycles
    tick(); core_rd = 1; core_addr = 9'h005;
    ext_req = 1; ext_we = 0; ext_addr = 9'h1FF;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("sv_gnt_c%0d", c), 32'(ext_gnt),
          32'(c == 4 || c == 9));
      chk($sformatf("sv_stall_c%0d", c), 32'(core_stall),
          32'(c == 4 || c == 9));
      chk($sformatf("sv_crv_c%0d", c), 32'(core_rd_valid),
          32'(c >= 1 && c != 5));
      chk($sformatf("sv_erv_c%0d", c), 32'(ext_rd_valid),
          32'(c == 5));
      if (c == 5) chk("sv_ext_data", ext_rd_data, 32'h12345678);
      if (c == 6) chk("sv_core_data", core_rd_data, 32'hDEADBEEF);
      tick();
    end
    idle_inputs();

    // ext_req dropped before grant restarts the wait window
    tick(); core_rd = 1; core_addr = 9'h005; ext_req = 1; ext_addr = 9'h1FF;
    tick();
    tick(); ext_req = 0;
    tick(); ext_req = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("drop_gnt_c%0d", c), 32'(ext_gnt), 32'(c == 4));
      tick();
    end
    idle_inputs();

    // rd and wr together: write wins
    tick(); core_rd = 1; core_wr = 1; core_addr = 9'h003;
    core_wr_data = 32'h55;
    @(negedge clk);
    chk("both_memwr", 32'(mem_wr), 32'h1);
    chk("both_memrd", 32'(mem_rd), 32'h0);
    tick(); idle_inputs();
    @(negedge clk);
    chk("both_no_valid", 32'(core_rd_valid), 32'h0);

    // reset pulse while a core read is pending
    tick(); core_rd = 1; core_addr = 9'h010;
    @(negedge clk);
    chk("rst_memrd", 32'(mem_rd), 32'h1);
    @(posedge clk);
    #1 core_rd = 0; reset = 1'b0;
    #2 chk("rst_in_valid", 32'(core_rd_valid), 32'h0);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_post_outs", all_out(), 32'h0);
    @(negedge clk);
    chk("rst_post_crv", 32'(core_rd_valid), 32'h0);
    chk("rst_post_outs2", all_out(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
